// File: rtl/mem_bridge.sv
// Data-side memory responder: RAM window plus UART MMIO (TX FIFO, RX holding register).
// Fixed 1-cycle read latency with same-word store-to-load bypass.
module mem_bridge #(
    parameter int          DATA_W         = 32,
    parameter int          RAM_AW         = 20,
    parameter int          TXF_DEPTH      = 4,
    parameter logic [31:0] UART_DATA_ADDR = 32'hBFD0_03F8,
    parameter logic [31:0] UART_STAT_ADDR = 32'hBFD0_03FC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       rd_addr,
    input  logic              rd_oe,
    input  logic              rd_wb,
    output logic [DATA_W-1:0] rd_data,
    input  logic [31:0]       wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_we,
    input  logic              wr_wb,
    output logic [RAM_AW-1:0] ram_raddr,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [RAM_AW-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [3:0]        ram_be,
    output logic              ram_we,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid
);

    localparam int TPW = $clog2(TXF_DEPTH);

    typedef enum logic [1:0] {
        T_NONE,
        T_RAM,
        T_UDATA,
        T_USTAT
    } tgt_t;

    logic rd_ram;
    logic rd_udata;
    logic rd_ustat;
    logic wr_ram;
    logic wr_udata;

    assign rd_ram   = rd_addr[31:22] == 10'b1000_0000_00;
    assign rd_udata = rd_addr == UART_DATA_ADDR;
    assign rd_ustat = rd_addr == UART_STAT_ADDR;
    assign wr_ram   = wr_addr[31:22] == 10'b1000_0000_00;
    assign wr_udata = wr_addr == UART_DATA_ADDR;

    // RAM port strobes
    assign ram_re    = rd_oe && rd_ram && !rst;
    assign ram_we    = wr_we && wr_ram && !rst;
    assign ram_raddr = rd_addr[RAM_AW+1:2];
    assign ram_waddr = wr_addr[RAM_AW+1:2];
    assign ram_be    = wr_wb ? (4'b0001 << wr_addr[1:0]) : 4'hF;
    assign ram_wdata = wr_wb ? {4{wr_data[7:0]}} : wr_data;

    tgt_t rd_tgt;

    always_comb begin
        rd_tgt = T_NONE;
        if (rd_oe) begin
            unique case (1'b1)
                rd_ram:   rd_tgt = T_RAM;
                rd_udata: rd_tgt = T_UDATA;
                rd_ustat: rd_tgt = T_USTAT;
                default:  rd_tgt = T_NONE;
            endcase
        end
    end

    logic do_udata_rd;
    logic do_ustat_rd;

    assign do_udata_rd = rd_tgt == T_UDATA;
    assign do_ustat_rd = rd_tgt == T_USTAT;

    // TX FIFO
    logic [7:0]   txf [TXF_DEPTH];
    logic [TPW-1:0] wp;
    logic [TPW-1:0] rp;
    logic [TPW:0]   cnt;
    logic           full;
    logic           push;
    logic           pop;

    assign full     = cnt == TPW'(0) + (TPW+1)'(TXF_DEPTH);
    assign tx_valid = cnt != '0;
    assign tx_data  = txf[rp];
    assign pop      = tx_valid && tx_ready;
    assign push     = wr_we && wr_udata && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < TXF_DEPTH; i++) begin
                txf[i] <= '0;
            end
        end else begin
            if (push) begin
                txf[wp] <= wr_data[7:0];
                wp      <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // RX holding register; a fresh byte always wins over a read-side clear
    logic [7:0] rx_buf;
    logic       rx_full;
    logic       overrun;
    logic       ovr_set;

    assign ovr_set = rx_valid && rx_full && !do_udata_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_buf  <= '0;
            rx_full <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (rx_valid) begin
                rx_buf  <= rx_data;
                rx_full <= 1'b1;
            end else if (do_udata_rd) begin
                rx_full <= 1'b0;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (do_ustat_rd) begin
                overrun <= 1'b0;
            end
        end
    end

    // Registered read request
    tgt_t              tgt_q;
    logic [1:0]        lane_q;
    logic              wb_q;
    logic [2:0]        stat_q;
    logic              byp_q;
    logic [DATA_W-1:0] byp_data_q;
    logic [3:0]        byp_be_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_q      <= T_NONE;
            lane_q     <= '0;
            wb_q       <= 1'b0;
            stat_q     <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
            byp_be_q   <= '0;
        end else begin
            tgt_q  <= rd_tgt;
            lane_q <= rd_addr[1:0];
            wb_q   <= rd_wb;
            if (do_ustat_rd) begin
                stat_q <= {overrun, rx_full, !full};
            end
            byp_q <= ram_we && ram_re && (ram_waddr == ram_raddr);
            if (ram_we) begin
                byp_data_q <= ram_wdata;
                byp_be_q   <= ram_be;
            end
        end
    end

    logic [DATA_W-1:0] merged;
    logic [7:0]        sel;

    always_comb begin
        merged = ram_rdata;
        for (int i = 0; i < 4; i++) begin
            if (byp_q && byp_be_q[i]) begin
                merged[i*8 +: 8] = byp_data_q[i*8 +: 8];
            end
        end
        sel = merged[{lane_q, 3'b000} +: 8];
    end

    always_comb begin
        rd_data = '0;
        case (tgt_q)
            T_RAM:   rd_data = wb_q ? {{(DATA_W-8){sel[7]}}, sel} : merged;
            T_UDATA: rd_data = {{(DATA_W-8){1'b0}}, rx_buf};
            T_USTAT: rd_data = {{(DATA_W-3){1'b0}}, stat_q};
            default: rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: read and TX expectations are queued at
// issue time and popped by monitors when the DUT presents them.
module tb_mem_bridge;

    localparam logic [31:0] UD = 32'hBFD0_03F8;
    localparam logic [31:0] US = 32'hBFD0_03FC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rd_addr = '0;
    logic        rd_oe = 1'b0;
    logic        rd_wb = 1'b0;
    logic [31:0] rd_data;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        wr_we = 1'b0;
    logic        wr_wb = 1'b0;
    logic [19:0] ram_raddr;
    logic        ram_re;
    logic [31:0] ram_rdata = '0;
    logic [19:0] ram_waddr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_we;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] rd_q [$];
    logic [7:0]  tx_q [$];
    logic        rd_pend;
    logic [31:0] mem [logic [19:0]];

    mem_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_oe     (rd_oe),
        .rd_wb     (rd_wb),
        .rd_data   (rd_data),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_we     (wr_we),
        .wr_wb     (wr_wb),
        .ram_raddr (ram_raddr),
        .ram_re    (ram_re),
        .ram_rdata (ram_rdata),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_be    (ram_be),
        .ram_we    (ram_we),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid)
    );

    always #5 clk = ~clk;

    // Read-first synchronous RAM model
    always @(posedge clk) begin
        logic [31:0] w;
        if (ram_re) ram_rdata <= mem.exists(ram_raddr) ? mem[ram_raddr] : 32'h0;
        if (ram_we) begin
            w = mem.exists(ram_waddr) ? mem[ram_waddr] : 32'h0;
            for (int i = 0; i < 4; i++)
                if (ram_be[i]) w[i*8 +: 8] = ram_wdata[i*8 +: 8];
            mem[ram_waddr] = w;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) rd_pend <= 1'b0;
        else     rd_pend <= rd_oe;
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rd_unexpected: got %h expected none", rd_data);
            end else begin
                check("rd_data", rd_data, rd_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL tx_unexpected: got %h expected none", tx_data);
            end else begin
                check("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rd_oe = 1'b0;
        rd_wb = 1'b0;
        wr_we = 1'b0;
        wr_wb = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic wb, input logic [31:0] exp);
        rd_addr = a;
        rd_wb = wb;
        rd_oe = 1'b1;
        rd_q.push_back(exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic wb);
        wr_addr = a;
        wr_data = d;
        wr_wb = wb;
        wr_we = 1'b1;
    endtask

    task automatic txpush(input logic [7:0] b);
        wr(UD, {24'h0, b}, 1'b0);
        tx_q.push_back(b);
        tick();
    endtask

    task automatic rxbyte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
    endtask

    task automatic drain();
        tx_ready = 1'b1;
        for (int i = 0; i < 20 && tx_valid; i++) tick();
        check("tx_drained", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_addr = 32'h8000_0010;
        rd_oe = 1'b1;
        wr_addr = 32'h8000_0010;
        wr_we = 1'b1;
        #2;
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_ram_re", {31'h0, ram_re}, 32'h0);
        check("rst_ram_we", {31'h0, ram_we}, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        wr(32'h8000_0010, 32'hDEAD_BEEF, 1'b0);
        #1;
        check("word_be", {28'h0, ram_be}, 32'hF);
        check("word_waddr", {12'h0, ram_waddr}, 32'h4);
        tick();
        rd(32'h8000_0010, 1'b0, 32'hDEAD_BEEF);
        tick();
        wr(32'h8000_0010, 32'h1122_3344, 1'b0);
        tick();

        wr(32'h8000_0013, 32'h0000_00A5, 1'b1);
        rd(32'h8000_0010, 1'b0, 32'hA522_3344);
        #1;
        check("byte_be", {28'h0, ram_be}, 32'h8);
        check("byte_wdata", ram_wdata, 32'hA5A5_A5A5);
        tick();
        rd(32'h8000_0013, 1'b1, 32'hFFFF_FFA5);
        tick();
        rd(32'h8000_0011, 1'b1, 32'h0000_0033);
        tick();
        rd(32'h8000_0012, 1'b0, 32'hA522_3344);
        tick();

        rd(32'h0000_1000, 1'b0, 32'h0);
        wr(32'h0000_1000, 32'hCAFE_F00D, 1'b0);
        #1;
        check("unmapped_we", {31'h0, ram_we}, 32'h0);
        tick();

        rd(US, 1'b0, 32'h1);
        tick();
        txpush(8'h41);
        txpush(8'h42);
        txpush(8'h43);
        txpush(8'h44);
        wr(UD, 32'h45, 1'b0);
        rd(US, 1'b0, 32'h0);
        tick();
        rd(US, 1'b0, 32'h0);
        tick();
        drain();

        txpush(8'h61);
        txpush(8'h62);
        txpush(8'h63);
        txpush(8'h64);
        tx_ready = 1'b1;
        wr(UD, 32'h50, 1'b0);
        tx_q.push_back(8'h50);
        tick();
        tx_ready = 1'b0;
        rd(US, 1'b0, 32'h0);
        tick();
        drain();

        txpush(8'h71);
        txpush(8'h72);
        txpush(8'h73);
        txpush(8'h74);
        rxbyte(8'h31);
        tick();
        rxbyte(8'h32);
        tick();
        rd(US, 1'b0, 32'h6);
        tick();
        rd(US, 1'b0, 32'h2);
        tick();
        rd(UD, 1'b0, 32'h32);
        tick();
        rd(US, 1'b0, 32'h0);
        tick();
        rxbyte(8'h34);
        tick();
        rxbyte(8'h35);
        rd(US, 1'b0, 32'h2);
        tick();
        rd(UD, 1'b0, 32'h35);
        tick();
        rd(US, 1'b0, 32'h4);
        tick();
        rd(US, 1'b0, 32'h0);
        tick();
        drain();
        rd(US, 1'b0, 32'h1);
        tick();

        txpush(8'h81);
        check("pre_rst_tx_valid", {31'h0, tx_valid}, 32'h1);
        rd_addr = 32'h8000_0010;
        rd_oe = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_rd_data", rd_data, 32'h0);
        check("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        tx_q.delete();
        tick();
        rst = 1'b0;
        rd(US, 1'b0, 32'h1);
        tick();
        tick();
        tick();

        check("rd_q_left", rd_q.size(), 32'h0);
        check("tx_q_left", tx_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
